// File: rtl/mac_operand_feeder_pkg.sv
// Shared types and constants for the MAC operand feeder: FSM state encoding,
// fp32 zero pattern, MAC cadence length and default register-file geometry.
package mac_feeder_pkg;

  localparam int DEPTH_DEFAULT = 16;
  localparam int AW_DEFAULT    = 4;
  localparam int PHASES        = 3;

  localparam logic [31:0] FP_ZERO = 32'h0000_0000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLR   = 3'd1,
    ST_FEED  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_HOLD  = 3'd4
  } state_e;

endpackage

// File: rtl/mac_operand_feeder_if.sv
// Bus bundle between the feeder, its host (writes/start/result) and the MAC.
// Handshake: a result transfers on any edge where result_valid_x70 and
// result_ready_x70 are both high; valid never drops before that transfer.
interface mac_operand_feeder_if
  import mac_feeder_pkg::*;
  #(parameter int AW = AW_DEFAULT);

  logic          wr_en_x70;
  logic          wr_sel_x70;
  logic [AW-1:0] wr_addr_x70;
  logic [31:0]   wr_data_x70;
  logic          start_x70;
  logic [AW:0]   len_x70;
  logic          busy_x70;
  logic          mac_rst_x70;
  logic [31:0]   mac_a_x70;
  logic [31:0]   mac_b_x70;
  logic [31:0]   mac_out_x70;
  logic [31:0]   result_x70;
  logic          result_valid_x70;
  logic          result_ready_x70;
  state_e        state_x70;

  modport slave (
    input  wr_en_x70, wr_sel_x70, wr_addr_x70, wr_data_x70,
    input  start_x70, len_x70, mac_out_x70, result_ready_x70,
    output busy_x70, mac_rst_x70, mac_a_x70, mac_b_x70,
    output result_x70, result_valid_x70, state_x70
  );

  modport master (
    output wr_en_x70, wr_sel_x70, wr_addr_x70, wr_data_x70,
    output start_x70, len_x70, mac_out_x70, result_ready_x70,
    input  busy_x70, mac_rst_x70, mac_a_x70, mac_b_x70,
    input  result_x70, result_valid_x70, state_x70
  );

endinterface

// File: rtl/mac_operand_feeder_operand_rf.sv
// Paired activation/weight register files: one shared write port steered by
// a select bit, and one combinational read port returning both entries at k.
module operand_rf #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic          sel_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   act_o,
  output logic [31:0]   wt_o
);

  logic [31:0] act_q [DEPTH];
  logic [31:0] wt_q  [DEPTH];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        act_q[i] <= '0;
        wt_q[i]  <= '0;
      end
    end else if (we_i) begin
      if (sel_i) wt_q[waddr_i]  <= wdata_i;
      else       act_q[waddr_i] <= wdata_i;
    end
  end

  assign act_o = act_q[raddr_i];
  assign wt_o  = wt_q[raddr_i];

endmodule

// File: rtl/mac_operand_feeder.sv
// Sequences stored activation/weight pairs into a 3-cycle fp32 MAC, drains it,
// and returns the captured dot product over a valid/ready handshake.
module mac_operand_feeder
  import mac_feeder_pkg::*;
  #(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int AW    = AW_DEFAULT
) (
  input  logic                clk_x70,
  input  logic                reset_x70,
  mac_operand_feeder_if.slave feed_if
);

  localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0]   N_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0] K_ONE   = AW'(1);
  localparam logic [1:0]    PH_LAST = 2'(PHASES - 1);

  state_e        state_q, state_d;
  logic [AW:0]   n_q, n_d;
  logic [AW-1:0] k_q, k_d;
  logic [1:0]    ph_q, ph_d;
  logic [31:0]   result_q, result_d;
  logic          valid_q, valid_d;
  logic          busy_q, busy_d;
  logic          mac_rst_q, mac_rst_d;
  logic [31:0]   mac_a_q, mac_a_d;
  logic [31:0]   mac_b_q, mac_b_d;
  logic [AW:0]   len_clamped;
  logic [31:0]   act_rd, wt_rd;

  // Read at the next term index so the registered operands line up with k.
  operand_rf #(.DEPTH(DEPTH), .AW(AW)) u_rf (
    .clk_i   (clk_x70),
    .rst_i   (reset_x70),
    .we_i    (feed_if.wr_en_x70 && (state_q == ST_IDLE)),
    .sel_i   (feed_if.wr_sel_x70),
    .waddr_i (feed_if.wr_addr_x70),
    .wdata_i (feed_if.wr_data_x70),
    .raddr_i (k_d),
    .act_o   (act_rd),
    .wt_o    (wt_rd)
  );

  assign len_clamped = (feed_if.len_x70 > DEPTH_L) ? DEPTH_L : feed_if.len_x70;

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    k_d      = k_q;
    ph_d     = ph_q;
    result_d = result_q;
    valid_d  = valid_q;
    unique case (state_q)
      ST_IDLE: begin
        if (feed_if.start_x70) begin
          n_d = len_clamped;
          if (len_clamped == '0) begin
            state_d  = ST_HOLD;
            result_d = FP_ZERO;
            valid_d  = 1'b1;
          end else begin
            state_d = ST_CLR;
          end
        end
      end
      ST_CLR: begin
        k_d     = '0;
        ph_d    = '0;
        state_d = ST_FEED;
      end
      ST_FEED: begin
        if (ph_q == PH_LAST) begin
          ph_d = '0;
          if ({1'b0, k_q} == n_q - N_ONE) state_d = ST_DRAIN;
          else                            k_d     = k_q + K_ONE;
        end else begin
          ph_d = ph_q + 2'd1;
        end
      end
      ST_DRAIN: begin
        // The last real product has been accumulated by the end of the zero triplet.
        if (ph_q == PH_LAST) begin
          ph_d     = '0;
          result_d = feed_if.mac_out_x70;
          valid_d  = 1'b1;
          state_d  = ST_HOLD;
        end else begin
          ph_d = ph_q + 2'd1;
        end
      end
      ST_HOLD: begin
        if (feed_if.result_ready_x70) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d    = (state_d != ST_IDLE);
    mac_rst_d = (state_d == ST_CLR);
    mac_a_d   = (state_d == ST_FEED) ? act_rd : FP_ZERO;
    mac_b_d   = (state_d == ST_FEED) ? wt_rd  : FP_ZERO;
  end

  always_ff @(posedge clk_x70 or posedge reset_x70) begin
    if (reset_x70) begin
      state_q   <= ST_IDLE;
      n_q       <= '0;
      k_q       <= '0;
      ph_q      <= '0;
      result_q  <= FP_ZERO;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      mac_rst_q <= 1'b1;
      mac_a_q   <= FP_ZERO;
      mac_b_q   <= FP_ZERO;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      k_q       <= k_d;
      ph_q      <= ph_d;
      result_q  <= result_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      mac_rst_q <= mac_rst_d;
      mac_a_q   <= mac_a_d;
      mac_b_q   <= mac_b_d;
    end
  end

  assign feed_if.busy_x70         = busy_q;
  assign feed_if.mac_rst_x70      = mac_rst_q;
  assign feed_if.mac_a_x70        = mac_a_q;
  assign feed_if.mac_b_x70        = mac_b_q;
  assign feed_if.result_x70       = result_q;
  assign feed_if.result_valid_x70 = valid_q;
  assign feed_if.state_x70        = state_q;

endmodule

// File: tb/tb_mac_operand_feeder.sv
// Directed bench for mac_operand_feeder with a behavioural 3-cycle fp32 MAC
// and a result queue filled at start and drained at each valid result.
module tb_mac_operand_feeder;
  import mac_feeder_pkg::*;

  logic clk_x70   = 1'b0;
  logic reset_x70 = 1'b0;

  mac_operand_feeder_if bus ();

  mac_operand_feeder dut (
    .clk_x70   (clk_x70),
    .reset_x70 (reset_x70),
    .feed_if   (bus)
  );

  always #5 clk_x70 = ~clk_x70;

  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] act_m [16];
  logic [31:0] wt_m  [16];

  function automatic real fp2r(input logic [31:0] b);
    real m;
    int  e;
    if (b[30:0] == 31'd0) return 0.0;
    m = 1.0 + real'(b[22:0]) / 8388608.0;
    e = int'(b[30:23]) - 127;
    while (e > 0) begin m = m * 2.0; e = e - 1; end
    while (e < 0) begin m = m / 2.0; e = e + 1; end
    return b[31] ? -m : m;
  endfunction

  function automatic logic [31:0] r2fp(input real v);
    logic        s;
    int          e;
    real         m;
    logic [22:0] f;
    if (v == 0.0) return 32'h0;
    s = (v < 0.0);
    m = s ? -v : v;
    e = 127;
    while (m >= 2.0) begin m = m / 2.0; e = e + 1; end
    while (m < 1.0)  begin m = m * 2.0; e = e - 1; end
    f = 23'($rtoi((m - 1.0) * 8388608.0));
    return {s, 8'(e), f};
  endfunction

  // Behavioural MAC: phase restarts after reset; product added on the third cycle.
  real        acc = 0.0;
  logic [1:0] mph = 2'd0;
  always @(posedge clk_x70) begin
    if (bus.mac_rst_x70) begin
      acc <= 0.0;
      mph <= 2'd0;
    end else begin
      mph <= (mph == 2'd2) ? 2'd0 : mph + 2'd1;
      if (mph == 2'd2) acc <= acc + fp2r(bus.mac_a_x70) * fp2r(bus.mac_b_x70);
    end
  end
  always_comb bus.mac_out_x70 = r2fp(acc);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] model_sum(input int n);
    real s = 0.0;
    for (int i = 0; i < n; i++) s = s + fp2r(act_m[i]) * fp2r(wt_m[i]);
    return r2fp(s);
  endfunction

  task automatic wr(input logic sel, input int addr, input logic [31:0] data);
    bus.wr_en_x70   = 1'b1;
    bus.wr_sel_x70  = sel;
    bus.wr_addr_x70 = 4'(addr);
    bus.wr_data_x70 = data;
    if (sel) wt_m[addr] = data; else act_m[addr] = data;
    @(negedge clk_x70);
    bus.wr_en_x70 = 1'b0;
  endtask

  task automatic clear_shadow();
    for (int i = 0; i < 16; i++) begin
      act_m[i] = 32'h0;
      wt_m[i]  = 32'h0;
    end
  endtask

  // Drives one run from an IDLE negedge and checks every cycle up to the return to IDLE.
  task automatic run(input int len, input logic [31:0] fixed_exp, input bit use_model,
                     input int rdy_wait, input bit wr_in_feed, input bit start_in_hold,
                     input bit wr_with_start);
    int n;
    logic [31:0] expv;
    logic [31:0] held;
    n = (len > 16) ? 16 : len;
    bus.start_x70 = 1'b1;
    bus.len_x70   = 5'(len);
    if (wr_with_start) begin
      bus.wr_en_x70   = 1'b1;
      bus.wr_sel_x70  = 1'b0;
      bus.wr_addr_x70 = 4'd0;
      bus.wr_data_x70 = r2fp(5.0);
      act_m[0]        = r2fp(5.0);
    end
    expv = use_model ? model_sum(n) : fixed_exp;
    exp_q.push_back(expv);
    if (rdy_wait == 0) bus.result_ready_x70 = 1'b1;
    @(negedge clk_x70);
    bus.start_x70 = 1'b0;
    bus.wr_en_x70 = 1'b0;
    chk("busy_c1", 32'(bus.busy_x70), 32'd1);
    if (n == 0) begin
      chk("mac_rst_len0", 32'(bus.mac_rst_x70), 32'd0);
    end else begin
      chk("mac_rst_clr", 32'(bus.mac_rst_x70), 32'd1);
      chk("valid_clr", 32'(bus.result_valid_x70), 32'd0);
      chk("mac_a_clr", bus.mac_a_x70, 32'h0);
      for (int t = 0; t < n; t++) begin
        for (int p = 0; p < 3; p++) begin
          @(negedge clk_x70);
          bus.wr_en_x70 = 1'b0;
          chk("mac_rst_feed", 32'(bus.mac_rst_x70), 32'd0);
          chk("mac_a_feed", bus.mac_a_x70, act_m[t]);
          chk("mac_b_feed", bus.mac_b_x70, wt_m[t]);
          if (wr_in_feed && t == 0 && p == 0) begin
            bus.wr_en_x70   = 1'b1;
            bus.wr_sel_x70  = 1'b1;
            bus.wr_addr_x70 = 4'd0;
            bus.wr_data_x70 = 32'h4120_0000;
          end
        end
      end
      for (int d = 0; d < 3; d++) begin
        @(negedge clk_x70);
        chk("mac_a_drain", bus.mac_a_x70, 32'h0);
        chk("mac_b_drain", bus.mac_b_x70, 32'h0);
        chk("valid_drain", 32'(bus.result_valid_x70), 32'd0);
      end
      @(negedge clk_x70);
    end
    chk("valid_rise", 32'(bus.result_valid_x70), 32'd1);
    if (exp_q.size() > 0) chk("result", bus.result_x70, exp_q.pop_front());
    else chk("exp_q_empty", 32'(exp_q.size()), 32'd1);
    held = bus.result_x70;
    for (int i = 0; i < rdy_wait; i++) begin
      bus.start_x70 = (start_in_hold && i == 1);
      bus.len_x70   = 5'd2;
      @(negedge clk_x70);
      chk("valid_hold", 32'(bus.result_valid_x70), 32'd1);
      chk("result_hold", bus.result_x70, held);
    end
    bus.start_x70 = 1'b0;
    bus.result_ready_x70 = 1'b1;
    @(negedge clk_x70);
    bus.result_ready_x70 = 1'b0;
    chk("valid_drop", 32'(bus.result_valid_x70), 32'd0);
    chk("busy_idle", 32'(bus.busy_x70), 32'd0);
    chk("state_idle", 32'(bus.state_x70), 32'(ST_IDLE));
  endtask

  task automatic load_plan();
    wr(1'b0, 0, 32'h3F80_0000);
    wr(1'b0, 1, 32'h4040_0000);
    wr(1'b1, 0, 32'h4000_0000);
    wr(1'b1, 1, 32'h4080_0000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.wr_en_x70        = 1'b0;
    bus.wr_sel_x70       = 1'b0;
    bus.wr_addr_x70      = '0;
    bus.wr_data_x70      = '0;
    bus.start_x70        = 1'b0;
    bus.len_x70          = '0;
    bus.result_ready_x70 = 1'b0;
    clear_shadow();

    #1 reset_x70 = 1'b1;
    #1;
    chk("rst_busy", 32'(bus.busy_x70), 32'd0);
    chk("rst_valid", 32'(bus.result_valid_x70), 32'd0);
    chk("rst_result", bus.result_x70, 32'h0);
    chk("rst_mac_a", bus.mac_a_x70, 32'h0);
    chk("rst_mac_b", bus.mac_b_x70, 32'h0);
    chk("rst_mac_rst", 32'(bus.mac_rst_x70), 32'd1);
    chk("rst_state", 32'(bus.state_x70), 32'(ST_IDLE));
    @(negedge clk_x70);
    reset_x70 = 1'b0;
    @(negedge clk_x70);
    chk("idle_mac_rst", 32'(bus.mac_rst_x70), 32'd0);

    // 1*2 + 3*4 = 14, with a stalled ready, an ignored start and an ignored FEED write.
    load_plan();
    run(2, 32'h4160_0000, 1'b0, 5, 1'b1, 1'b1, 1'b0);
    run(2, 32'h4160_0000, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    run(0, 32'h0000_0000, 1'b0, 2, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 16; i++) begin
      wr(1'b0, i, 32'h3F80_0000);
      wr(1'b1, i, 32'h3F80_0000);
    end
    run(20, 32'h4180_0000, 1'b0, 1, 1'b0, 1'b0, 1'b0);

    for (int r = 0; r < 3; r++) begin
      int len;
      for (int i = 0; i < 16; i++) begin
        wr(1'b0, i, r2fp(real'($urandom_range(0, 7))));
        wr(1'b1, i, r2fp(real'($urandom_range(0, 7))));
      end
      len = $urandom_range(1, 16);
      run(len, 32'h0, 1'b1, $urandom_range(0, 3), 1'b0, 1'b0, (r == 1));
    end

    // Reset while feeding term 1, then confirm clean recovery.
    load_plan();
    bus.start_x70 = 1'b1;
    bus.len_x70   = 5'd2;
    @(negedge clk_x70);
    bus.start_x70 = 1'b0;
    for (int i = 0; i < 4; i++) @(negedge clk_x70);
    chk("pre_rst_mac_a", bus.mac_a_x70, act_m[1]);
    #2 reset_x70 = 1'b1;
    #1;
    chk("midrst_valid", 32'(bus.result_valid_x70), 32'd0);
    chk("midrst_mac_rst", 32'(bus.mac_rst_x70), 32'd1);
    chk("midrst_busy", 32'(bus.busy_x70), 32'd0);
    chk("midrst_state", 32'(bus.state_x70), 32'(ST_IDLE));
    chk("midrst_mac_a", bus.mac_a_x70, 32'h0);
    @(negedge clk_x70);
    reset_x70 = 1'b0;
    clear_shadow();
    @(negedge clk_x70);
    run(2, 32'h0000_0000, 1'b0, 1, 1'b0, 1'b0, 1'b0);
    load_plan();
    run(2, 32'h4160_0000, 1'b0, 2, 1'b0, 1'b0, 1'b0);

    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
